// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the l2_cache line port between the L1 I-cache and D-cache.
// Registered request/response path with round-robin or fixed-D arbitration.
module l2_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int LINE_W   = 256,
    parameter int OFFSET_W = 5,
    parameter int ARB_MODE = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic              i_mem_read,
    output logic [LINE_W-1:0] i_mem_rdata256,
    output logic              i_mem_resp,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [LINE_W-1:0] d_mem_wdata256,
    output logic [LINE_W-1:0] d_mem_rdata256,
    output logic              d_mem_resp,
    output logic [ADDR_W-1:0] l2_mem_address,
    output logic              l2_mem_read,
    output logic              l2_mem_write,
    output logic [LINE_W-1:0] l2_mem_wdata256,
    input  logic [LINE_W-1:0] l2_mem_rdata256,
    input  logic              l2_mem_resp,
    output logic              busy,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam logic FIXED_D = (ARB_MODE != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              sel_d_q, sel_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] irdata_q, irdata_d;
    logic [LINE_W-1:0] drdata_q, drdata_d;
    logic              iresp_q, iresp_d;
    logic              dresp_q, dresp_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;

    logic req_i, req_d, gnt_i, gnt_d;

    assign req_i = i_mem_read;
    assign req_d = d_mem_read | d_mem_write;
    // on a tie D wins when it has fixed priority or when I was served last
    assign gnt_d = req_d & (~req_i | FIXED_D | ~last_d_q);
    assign gnt_i = req_i & ~gnt_d;

    // next-state: arbitration in IDLE, hold during SERVE, one-cycle resp pulse
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        sel_d_d  = sel_d_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        iresp_d  = 1'b0;
        dresp_d  = 1'b0;
        icnt_d   = icnt_q;
        dcnt_d   = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    state_d  = SERVE_D;
                    last_d_d = 1'b1;
                    sel_d_d  = 1'b1;
                    addr_d   = {d_mem_address[ADDR_W-1:OFFSET_W],
                                {OFFSET_W{1'b0}}};
                    wr_d     = d_mem_write;
                    rd_d     = d_mem_read & ~d_mem_write;
                    wdata_d  = d_mem_wdata256;
                    if (~&dcnt_q) dcnt_d = dcnt_q + CNT_ONE;
                end else if (gnt_i) begin
                    state_d  = SERVE_I;
                    last_d_d = 1'b0;
                    sel_d_d  = 1'b0;
                    addr_d   = {i_mem_address[ADDR_W-1:OFFSET_W],
                                {OFFSET_W{1'b0}}};
                    wr_d     = 1'b0;
                    rd_d     = 1'b1;
                    wdata_d  = '0;
                    if (~&icnt_q) icnt_d = icnt_q + CNT_ONE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_mem_resp) begin
                    state_d = RESP;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (sel_d_q) begin
                        drdata_d = l2_mem_rdata256;
                        dresp_d  = 1'b1;
                    end else begin
                        irdata_d = l2_mem_rdata256;
                        iresp_d  = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // state and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            sel_d_q  <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            iresp_q  <= 1'b0;
            dresp_q  <= 1'b0;
            busy_q   <= 1'b0;
            icnt_q   <= '0;
            dcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            sel_d_q  <= sel_d_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            iresp_q  <= iresp_d;
            dresp_q  <= dresp_d;
            busy_q   <= busy_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
        end
    end

    assign i_mem_rdata256  = irdata_q;
    assign i_mem_resp      = iresp_q;
    assign d_mem_rdata256  = drdata_q;
    assign d_mem_resp      = dresp_q;
    assign l2_mem_address  = addr_q;
    assign l2_mem_read     = rd_q;
    assign l2_mem_write    = wr_q;
    assign l2_mem_wdata256 = wdata_q;
    assign busy            = busy_q;
    assign i_grant_cnt     = icnt_q;
    assign d_grant_cnt     = dcnt_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: three arbiter instances (round-robin, fixed-D, 2-bit counters)
// driven in lockstep, each answered by a fixed-latency L2 model.
module tb_l2_arbiter;

    logic         clk;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_rd;
    logic [31:0]  d_addr;
    logic         d_rd;
    logic         d_wr;
    logic [255:0] d_wdata;
    logic [255:0] l2_rdata;

    logic [255:0] irdata  [3];
    logic [255:0] drdata  [3];
    logic [255:0] l2wdata [3];
    logic [31:0]  l2addr  [3];
    logic         iresp   [3];
    logic         dresp   [3];
    logic         l2rd    [3];
    logic         l2wr    [3];
    logic         l2resp  [3];
    logic         busy    [3];
    logic [15:0]  icnt    [3];
    logic [15:0]  dcnt    [3];

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CW = (k == 2) ? 2 : 16;
        localparam int AM = (k == 1) ? 1 : 0;
        logic [CW-1:0] ic, dc;
        logic [3:0]    c;
        logic          r;

        l2_arbiter #(
            .ADDR_W(32), .LINE_W(256), .OFFSET_W(5),
            .ARB_MODE(AM), .CNT_W(CW)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .i_mem_address(i_addr),
            .i_mem_read(i_rd),
            .i_mem_rdata256(irdata[k]),
            .i_mem_resp(iresp[k]),
            .d_mem_address(d_addr),
            .d_mem_read(d_rd),
            .d_mem_write(d_wr),
            .d_mem_wdata256(d_wdata),
            .d_mem_rdata256(drdata[k]),
            .d_mem_resp(dresp[k]),
            .l2_mem_address(l2addr[k]),
            .l2_mem_read(l2rd[k]),
            .l2_mem_write(l2wr[k]),
            .l2_mem_wdata256(l2wdata[k]),
            .l2_mem_rdata256(l2_rdata),
            .l2_mem_resp(l2resp[k]),
            .busy(busy[k]),
            .i_grant_cnt(ic),
            .d_grant_cnt(dc)
        );

        assign icnt[k]   = 16'(ic);
        assign dcnt[k]   = 16'(dc);
        assign l2resp[k] = r;

        // L2 model: answers 5 cycles after a request appears
        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                c <= '0;
                r <= 1'b0;
            end else if (r) begin
                r <= 1'b0;
                c <= '0;
            end else if (l2rd[k] | l2wr[k]) begin
                if (c == 4'd4) r <= 1'b1;
                else c <= c + 4'd1;
            end
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        i_rd = 0; d_rd = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        rst = 0;
        tick(); tick();
        rst = 1;
        tick();
    endtask

    task automatic test_reset;
        bit seen;
        do_reset();
        total++;
        if (busy[0] !== 0 || l2rd[0] !== 0 || l2wr[0] !== 0 ||
            l2addr[0] !== 0 || icnt[0] !== 0 || dcnt[0] !== 0 ||
            irdata[0] !== 0 || drdata[0] !== 0) begin
            bad++;
            $display("FAIL reset_state busy=%0b rd=%0b wr=%0b addr=%h want all 0",
                     busy[0], l2rd[0], l2wr[0], l2addr[0]);
        end
        d_addr = 32'h8000_0040; d_wdata = 256'h3; d_wr = 1;
        seen = 0;
        for (int n = 0; n < 5 && !seen; n++) begin
            tick();
            seen = l2wr[0];
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL reset_serve_d l2_mem_write=0 want 1");
        end
        #2 rst = 0;
        #1;
        total++;
        if (busy[0] !== 0 || l2rd[0] !== 0 || l2wr[0] !== 0 ||
            l2addr[0] !== 0 || l2wdata[0] !== 0 || dresp[0] !== 0 ||
            iresp[0] !== 0 || dcnt[0] !== 0 || icnt[0] !== 0) begin
            bad++;
            $display("FAIL async_reset busy=%0b wr=%0b addr=%h dcnt=%0d want 0",
                     busy[0], l2wr[0], l2addr[0], dcnt[0]);
        end
        d_wr = 0;
        tick();
        rst = 1;
        tick();
        total++;
        if (busy[0] !== 0) begin
            bad++;
            $display("FAIL reset_release_busy got=%0b want 0", busy[0]);
        end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (dresp[0] || l2wr[0]) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL reset_no_resp activity seen after reset, want none");
        end
    endtask

    task automatic test_i_only;
        bit got, prev;
        do_reset();
        l2_rdata = {32{8'hA5}};
        i_addr = 32'h0000_1234; i_rd = 1;
        tick();
        total++;
        if (l2rd[0] !== 1 || l2wr[0] !== 0 || l2addr[0] !== 32'h0000_1220) begin
            bad++;
            $display("FAIL i_l2_req rd=%0b wr=%0b addr=%h want 1 0 00001220",
                     l2rd[0], l2wr[0], l2addr[0]);
        end
        got = 0; prev = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (iresp[0]) begin
                got = 1;
                total++;
                if (!prev) begin
                    bad++;
                    $display("FAIL i_resp_latency l2_resp_prev=0 want 1");
                end
                total++;
                if (irdata[0] !== {32{8'hA5}} || dresp[0] !== 0) begin
                    bad++;
                    $display("FAIL i_rdata got=%h dresp=%0b want a5.. 0",
                             irdata[0], dresp[0]);
                end
            end else begin
                prev = l2resp[0];
                tick();
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL i_resp_timeout got=0 want 1");
        end
        i_rd = 0;
        tick();
        total++;
        if (iresp[0] !== 0 || busy[0] !== 0 || l2rd[0] !== 0) begin
            bad++;
            $display("FAIL i_resp_pulse resp=%0b busy=%0b rd=%0b want 0 0 0",
                     iresp[0], busy[0], l2rd[0]);
        end
        total++;
        if (icnt[0] !== 16'd1 || dcnt[0] !== 16'd0) begin
            bad++;
            $display("FAIL i_grant_cnt got=%0d/%0d want 1/0", icnt[0], dcnt[0]);
        end
    endtask

    task automatic test_d_write;
        bit got, prev, istray;
        do_reset();
        l2_rdata = 256'h77;
        d_addr = 32'h8000_0040; d_wdata = 256'h1; d_wr = 1; d_rd = 1;
        tick();
        total++;
        if (l2wr[0] !== 1 || l2rd[0] !== 0 || l2addr[0] !== 32'h8000_0040 ||
            l2wdata[0] !== 256'h1) begin
            bad++;
            $display("FAIL d_l2_req wr=%0b rd=%0b addr=%h wd=%h want 1 0 80000040 1",
                     l2wr[0], l2rd[0], l2addr[0], l2wdata[0]);
        end
        d_addr = 32'hFFFF_FFFF; d_wdata = 256'h2;
        got = 0; prev = 0; istray = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            if (iresp[0]) istray = 1;
            if (dresp[0]) begin
                got = 1;
                total++;
                if (!prev) begin
                    bad++;
                    $display("FAIL d_resp_latency l2_resp_prev=0 want 1");
                end
                total++;
                if (drdata[0] !== 256'h77 || l2addr[0] !== 32'h8000_0040 ||
                    l2wdata[0] !== 256'h1) begin
                    bad++;
                    $display("FAIL d_latched rdata=%h addr=%h wd=%h want 77 80000040 1",
                             drdata[0], l2addr[0], l2wdata[0]);
                end
            end else begin
                prev = l2resp[0];
                tick();
            end
        end
        total++;
        if (!got || istray) begin
            bad++;
            $display("FAIL d_resp got=%0b i_resp_seen=%0b want 1 0", got, istray);
        end
        d_wr = 0; d_rd = 0;
        tick();
        total++;
        if (dresp[0] !== 0 || irdata[0] !== 0 || dcnt[0] !== 16'd1) begin
            bad++;
            $display("FAIL d_after resp=%0b irdata=%h dcnt=%0d want 0 0 1",
                     dresp[0], irdata[0], dcnt[0]);
        end
    endtask

    task automatic test_tie;
        bit seq0 [4];
        int n0, n1i, n1d;
        do_reset();
        l2_rdata = 256'h5;
        i_addr = 32'h100; d_addr = 32'h200;
        i_rd = 1; d_rd = 1;
        n0 = 0; n1i = 0; n1d = 0;
        for (int n = 0; n < 200 && n0 < 4; n++) begin
            tick();
            if (iresp[0]) begin seq0[n0] = 0; n0++; end
            if (dresp[0]) begin seq0[n0] = 1; n0++; end
            if (iresp[1]) n1i++;
            if (dresp[1]) n1d++;
        end
        total++;
        if (n0 != 4) begin
            bad++;
            $display("FAIL tie_timeout grants=%0d want 4", n0);
        end else begin
            for (int g = 0; g < 4; g++) begin
                total++;
                if (seq0[g] !== g[0]) begin
                    bad++;
                    $display("FAIL tie_rr_order grant%0d is_d=%0b want %0b",
                             g, seq0[g], g[0]);
                end
            end
        end
        total++;
        if (icnt[0] !== 16'd2 || dcnt[0] !== 16'd2) begin
            bad++;
            $display("FAIL tie_rr_cnt got=%0d/%0d want 2/2", icnt[0], dcnt[0]);
        end
        total++;
        if (n1i != 0 || n1d != 4 || icnt[1] !== 16'd0 || dcnt[1] !== 16'd4) begin
            bad++;
            $display("FAIL tie_fixed i=%0d d=%0d icnt=%0d dcnt=%0d want 0 4 0 4",
                     n1i, n1d, icnt[1], dcnt[1]);
        end
        i_rd = 0; d_rd = 0;
        tick(); tick();
    endtask

    task automatic test_saturation;
        bit got;
        do_reset();
        i_addr = 32'h40;
        for (int t = 0; t < 5; t++) begin
            i_rd = 1;
            got = 0;
            for (int n = 0; n < 40 && !got; n++) begin
                tick();
                got = iresp[2];
            end
            total++;
            if (!got) begin
                bad++;
                $display("FAIL sat_timeout txn%0d got=0 want 1", t);
            end
            i_rd = 0;
            tick();
        end
        total++;
        if (icnt[2] !== 16'd3 || icnt[0] !== 16'd5) begin
            bad++;
            $display("FAIL sat_cnt cnt2=%0d cnt16=%0d want 3 5", icnt[2], icnt[0]);
        end
    endtask

    initial begin
        rst = 0; i_rd = 0; d_rd = 0; d_wr = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
        test_reset();
        test_i_only();
        test_d_write();
        test_tie();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
